fft_pair_merge: RTL and testbench

- Sits directly after a radix-2 butterfly stage.
- The stage emits its results as two parallel lane groups per cycle: the "add" half and the "sub" half, each 16 complex lanes.
- This block merges the two halves back into one 16-lane complex stream in natural block order: all add beats of a block first, then all sub beats.
- Add beats pass straight through. Sub beats are buffered internally and drained afterwards.
- The block back-pressures the upstream stage while it drains.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_merge_buf.sv | 29 ++
 rtl/fft_pair_merge.sv | 166 ++++++++++++++++
 tb/tb_fft_pair_merge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and default constants for the FFT pair-merge slice.
package fft_pkg;

    localparam int unsigned FFT_IN_W    = 11;
    localparam int unsigned FFT_LANES   = 16;
    localparam int unsigned FFT_BLK_CYC = 8;

    typedef struct packed {
        logic signed [FFT_IN_W-1:0] re;
        logic signed [FFT_IN_W-1:0] im;
    } cpx_t;

    typedef cpx_t [FFT_LANES-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DRAIN
    } state_t;

    // Counter width that stays legal for a one-beat block.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_merge_buf.sv
// Sub-half beat store: one write port, one combinational read port, no reset on contents.
module fft_merge_buf
    import fft_pkg::*;
#(
    parameter int unsigned IN_W    = FFT_IN_W,
    parameter int unsigned LANES   = FFT_LANES,
    parameter int unsigned BLK_CYC = FFT_BLK_CYC,
    localparam int unsigned AW     = cnt_w(BLK_CYC),
    localparam int unsigned EW     = 2 * IN_W
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [LANES-1:0][EW-1:0]   wr_data,
    input  logic [AW-1:0]              rd_addr,
    output logic [LANES-1:0][EW-1:0]   rd_data
);

    logic [LANES-1:0][EW-1:0] mem [BLK_CYC];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_pair_merge.sv
// Merges butterfly add/sub halves into one block-ordered stream; sub beats are buffered and drained.
// Optional output round-and-halve with saturation is enabled by defining FFT_MERGE_SCALE_EN.
module fft_pair_merge
    import fft_pkg::*;
#(
    parameter int unsigned IN_W    = FFT_IN_W,
    parameter int unsigned LANES   = FFT_LANES,
    parameter int unsigned BLK_CYC = FFT_BLK_CYC,
`ifdef FFT_MERGE_SCALE_EN
    localparam int unsigned OUT_W  = IN_W - 1,
`else
    localparam int unsigned OUT_W  = IN_W,
`endif
    localparam int unsigned CW     = cnt_w(BLK_CYC)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic [LANES-1:0][IN_W-1:0]   din_add_r,
    input  logic [LANES-1:0][IN_W-1:0]   din_add_i,
    input  logic [LANES-1:0][IN_W-1:0]   din_sub_r,
    input  logic [LANES-1:0][IN_W-1:0]   din_sub_i,
    output logic                         dout_valid,
    output logic [LANES-1:0][OUT_W-1:0]  dout_r,
    output logic [LANES-1:0][OUT_W-1:0]  dout_i,
    output logic                         dout_first,
    output logic                         dout_last
);

    state_t state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;

    logic accept, drain, wr_last, rd_last;

    logic [LANES-1:0][2*IN_W-1:0] buf_wr, buf_rd;
    logic [LANES-1:0][IN_W-1:0]   sel_r, sel_i;
    logic [LANES-1:0][OUT_W-1:0]  out_r_d, out_i_d;

    logic                         dout_valid_q, dout_first_q, dout_last_q;
    logic [LANES-1:0][OUT_W-1:0]  dout_r_q, dout_i_q;

    assign accept  = din_valid && din_ready;
    assign wr_last = (wr_cnt_q == CW'(BLK_CYC - 1));
    assign rd_last = (rd_cnt_q == CW'(BLK_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = wr_last ? DRAIN : PASS;
            PASS:    if (accept && wr_last) state_d = DRAIN;
            DRAIN:   if (rd_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        din_ready = (state_q != DRAIN);
        drain     = (state_q == DRAIN);
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (accept) begin
            wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
        end
        if (drain) begin
            rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            buf_wr[k] = {din_sub_r[k], din_sub_i[k]};
        end
    end

    fft_merge_buf #(
        .IN_W    (IN_W),
        .LANES   (LANES),
        .BLK_CYC (BLK_CYC)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_cnt_q),
        .wr_data (buf_wr),
        .rd_addr (rd_cnt_q),
        .rd_data (buf_rd)
    );

`ifdef FFT_MERGE_SCALE_EN
    // (x + 1) >>> 1 at one guard bit, clamped to the narrower output range.
    function automatic logic [OUT_W-1:0] scale(input logic [IN_W-1:0] x);
        logic signed [IN_W:0] t, hi, lo;
        hi = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
        lo = ~hi;
        t  = $signed({x[IN_W-1], x}) + $signed((IN_W+1)'(1));
        t  = t >>> 1;
        if (t > hi) begin
            t = hi;
        end else if (t < lo) begin
            t = lo;
        end
        return t[OUT_W-1:0];
    endfunction
`endif

    // Accept and drain never coincide, so one mux serves both output paths.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            if (accept) begin
                sel_r[k] = din_add_r[k];
                sel_i[k] = din_add_i[k];
            end else begin
                sel_r[k] = buf_rd[k][2*IN_W-1:IN_W];
                sel_i[k] = buf_rd[k][IN_W-1:0];
            end
`ifdef FFT_MERGE_SCALE_EN
            out_r_d[k] = scale(sel_r[k]);
            out_i_d[k] = scale(sel_i[k]);
`else
            out_r_d[k] = sel_r[k];
            out_i_d[k] = sel_i[k];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_valid_q <= 1'b0;
            dout_first_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_r_q     <= '0;
            dout_i_q     <= '0;
        end else begin
            dout_valid_q <= accept || drain;
            dout_first_q <= accept && (wr_cnt_q == '0);
            dout_last_q  <= drain && rd_last;
            if (accept || drain) begin
                dout_r_q <= out_r_d;
                dout_i_q <= out_i_d;
            end
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_first = dout_first_q;
    assign dout_last  = dout_last_q;
    assign dout_r     = dout_r_q;
    assign dout_i     = dout_i_q;

endmodule

// File: tb/tb_fft_pair_merge.sv
// Directed bench for fft_pair_merge: block ordering, gaps, backpressure, resets and scaling.
`timescale 1ns/1ps
module tb_fft_pair_merge;

    localparam int IN_W    = 11;
    localparam int LANES   = 16;
    localparam int BLK_CYC = 8;
`ifdef FFT_MERGE_SCALE_EN
    localparam int OUT_W   = IN_W - 1;
`else
    localparam int OUT_W   = IN_W;
`endif

    typedef logic [LANES-1:0][IN_W-1:0]  in_vec_t;
    typedef logic [LANES-1:0][OUT_W-1:0] out_vec_t;

    typedef struct {
        int       cyc;
        out_vec_t r;
        out_vec_t i;
        logic     first;
        logic     last;
    } obeat_t;

    typedef struct {
        int in_val;
        int exp_scaled;
    } svec_t;

    logic    clk = 1'b0;
    logic    rstn = 1'b0;
    logic    din_valid = 1'b0;
    logic    din_ready;
    in_vec_t din_add_r = '0, din_add_i = '0, din_sub_r = '0, din_sub_i = '0;
    logic    dout_valid, dout_first, dout_last;
    out_vec_t dout_r, dout_i;

    always #5 clk = ~clk;

    fft_pair_merge dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_add_r  (din_add_r),
        .din_add_i  (din_add_i),
        .din_sub_r  (din_sub_r),
        .din_sub_i  (din_sub_i),
        .dout_valid (dout_valid),
        .dout_r     (dout_r),
        .dout_i     (dout_i),
        .dout_first (dout_first),
        .dout_last  (dout_last)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_rdy_low = 0;
    obeat_t oq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn && din_valid && din_ready) n_acc++;
        if (!din_ready) n_rdy_low++;
        if (dout_valid) oq.push_back('{cyc, dout_r, dout_i, dout_first, dout_last});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_val(input int v);
`ifdef FFT_MERGE_SCALE_EN
        int t;
        t = (v + 1) >>> 1;
        if (t > 2**(OUT_W-1) - 1) t = 2**(OUT_W-1) - 1;
        if (t < -(2**(OUT_W-1))) t = -(2**(OUT_W-1));
        return t;
`else
        return v;
`endif
    endfunction

    function automatic in_vec_t pat(input int base);
        in_vec_t v;
        for (int k = 0; k < LANES; k++) v[k] = IN_W'(base + k);
        return v;
    endfunction

    function automatic out_vec_t exp_vec(input int base);
        out_vec_t v;
        for (int k = 0; k < LANES; k++) v[k] = OUT_W'(exp_val(base + k));
        return v;
    endfunction

    task automatic send_beat(input in_vec_t ar, input in_vec_t ai,
                             input in_vec_t sr, input in_vec_t si);
        bit ok;
        int guard;
        ok = 1'b0;
        guard = 0;
        din_add_r = ar;
        din_add_i = ai;
        din_sub_r = sr;
        din_sub_i = si;
        din_valid = 1'b1;
        while (!ok && guard < 64) begin
            @(negedge clk);
            ok = din_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: din_ready stayed 0, required 1 within 64 cycles");
        end
    endtask

    task automatic send_block(input int base, input logic [7:0] gap_mask);
        for (int b = 0; b < BLK_CYC; b++) begin
            send_beat(pat(base + 16*b), pat(base + 16*b),
                      pat(base + 128 + 16*b), pat(base + 128 + 16*b));
            if (gap_mask[b]) begin
                din_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected merged order: beat n carries value base + 16*n + k in lane k.
    task automatic check_block(input string name, input int base, input int start);
        logic [511:0] exp, act;
        int j;
        for (int n = 0; n < 2*BLK_CYC; n++) begin
            j = start + n;
            exp = {exp_vec(base + 16*n), exp_vec(base + 16*n), n == 0, n == 2*BLK_CYC-1};
            if (j < oq.size()) act = {oq[j].r, oq[j].i, oq[j].first, oq[j].last};
            else act = '1;
            check($sformatf("%s_beat%0d", name, n), act, exp);
        end
    endtask

    task automatic do_reset_check(input string name);
        rstn = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_valid"}, 512'(dout_valid), 512'(0));
        check({name, "_r"}, 512'(dout_r), 512'(0));
        check({name, "_i"}, 512'(dout_i), 512'(0));
        check({name, "_ready"}, 512'(din_ready), 512'(1));
        rstn = 1'b1;
        oq.delete();
        n_acc = 0;
    endtask

    svec_t stab[5];

    initial begin
        stab[0] = '{1023, 511};
        stab[1] = '{-1024, -512};
        stab[2] = '{3, 2};
        stab[3] = '{-3, -1};
        stab[4] = '{1, 1};

        // Reset held with valid asserted.
        din_add_r = pat(100);
        din_add_i = pat(100);
        din_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 512'(din_ready), 512'(1));
        check("rst_valid", 512'(dout_valid), 512'(0));
        check("rst_r", 512'(dout_r), 512'(0));
        check("rst_i", 512'(dout_i), 512'(0));
        rstn = 1'b1;
        din_valid = 1'b0;
        idle(3);
        check("rst_no_output", 512'(oq.size()), 512'(0));
        check("rst_no_accept", 512'(n_acc), 512'(0));

        // Back-to-back block.
        oq.delete();
        n_acc = 0;
        n_rdy_low = 0;
        send_block(0, 8'h00);
        idle(12);
        check("b2b_count", 512'(oq.size()), 512'(16));
        check_block("b2b", 0, 0);
        if (oq.size() >= 16) check("b2b_contig", 512'(oq[15].cyc - oq[0].cyc), 512'(15));
        check("b2b_ready_low", 512'(n_rdy_low), 512'(8));
        check("b2b_accepts", 512'(n_acc), 512'(8));

        // Input gaps after beats 2 and 5.
        oq.delete();
        send_block(0, 8'b0010_0100);
        idle(12);
        check("gap_count", 512'(oq.size()), 512'(16));
        check_block("gap", 0, 0);
        if (oq.size() >= 16) begin
            check("gap_hole1", 512'(oq[3].cyc - oq[2].cyc), 512'(2));
            check("gap_hole2", 512'(oq[6].cyc - oq[5].cyc), 512'(2));
            check("gap_span", 512'(oq[15].cyc - oq[0].cyc), 512'(17));
        end

        // Three blocks with din_valid held high throughout.
        oq.delete();
        n_acc = 0;
        send_block(0, 8'h00);
        send_block(256, 8'h00);
        send_block(512, 8'h00);
        idle(14);
        check("bp_accepts", 512'(n_acc), 512'(24));
        check("bp_outputs", 512'(oq.size()), 512'(48));
        check_block("bp_blk0", 0, 0);
        check_block("bp_blk1", 256, 16);
        check_block("bp_blk2", 512, 32);
        if (oq.size() >= 48) begin
            check("bp_next1", 512'(oq[16].cyc - oq[15].cyc), 512'(1));
            check("bp_next2", 512'(oq[32].cyc - oq[31].cyc), 512'(1));
        end

        // Reset after three beats of a block.
        oq.delete();
        for (int b = 0; b < 3; b++) send_beat(pat(16*b), pat(16*b), pat(128+16*b), pat(128+16*b));
        do_reset_check("rst_mid");
        send_block(256, 8'h00);
        idle(12);
        check("rst_mid_count", 512'(oq.size()), 512'(16));
        check_block("rst_mid", 256, 0);

        // Reset while draining.
        oq.delete();
        send_block(0, 8'h00);
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_drain_pre", 512'(din_ready), 512'(0));
        do_reset_check("rst_drain");
        send_block(512, 8'h00);
        idle(12);
        check("rst_drain_count", 512'(oq.size()), 512'(16));
        check_block("rst_drain", 512, 0);

        // Scaling / pass-through table on add beats 0..4.
        oq.delete();
        for (int b = 0; b < BLK_CYC; b++) begin
            in_vec_t v;
            v = '0;
            if (b < 5) for (int k = 0; k < LANES; k++) v[k] = IN_W'(stab[b].in_val);
            send_beat(v, v, '0, '0);
        end
        idle(12);
        check("scale_count", 512'(oq.size()), 512'(16));
        for (int t = 0; t < 5; t++) begin
            logic [OUT_W-1:0] e;
`ifdef FFT_MERGE_SCALE_EN
            e = OUT_W'(stab[t].exp_scaled);
`else
            e = OUT_W'(stab[t].in_val);
`endif
            if (t < oq.size()) begin
                check($sformatf("scale%0d_r", t), 512'(oq[t].r[0]), 512'(e));
                check($sformatf("scale%0d_i", t), 512'(oq[t].i[LANES-1]), 512'(e));
            end else begin
                check($sformatf("scale%0d_missing", t), 512'(oq.size()), 512'(16));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
